alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle controller that owns a 4-entry x 8-bit register file and sequences the shared combinational 8-bit ALU (op 0 add, 1 sub, 2 pass r1, 3 shl, 4 shr, 5 and, 6 not r1, 7 or). It accepts commands over a valid/ready handshake and drives the ALU operand and op ports. Single-op commands take one ALU cycle. MUL is executed as an 8-iteration shift-add sequence on the same ALU. The ALU instance sits outside this block and connects to the alu_* ports.

Parameters:
NUM_REGS, 4, register file depth (address width 2); fixed
MUL_ITERS, 8, shift-add iterations for MUL; must equal data width 8

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept; equals (state==IDLE)
cmd_code  input  4  0-7 ALU op, 8 LOADI, 9 MUL, 10-15 illegal
cmd_rd  input  2  destination register
cmd_rs1  input  2  source 1 register
cmd_rs2  input  2  source 2 register
cmd_imm  input  8  LOADI immediate
alu_r1  output  8  ALU operand 1
alu_r2  output  8  ALU operand 2
alu_op  output  3  ALU op select
alu_out  input  8  ALU result (combinational from alu_r1/alu_r2/alu_op)
done  output  1  one-cycle pulse: command retired
result  output  8  value written by last retired command
err  output  1  one-cycle pulse with done for an illegal code
busy  output  1  state != IDLE
dbg_addr  input  2  debug read address
dbg_data  output  8  combinational regfile[dbg_addr]

Behaviour:
- Async reset: state IDLE, regfile all 0, result 0, done 0, err 0, MUL temporaries 0. Reset mid-command abandons the command: no write, no done.
- Handshake: accept at the rising edge where cmd_valid & cmd_ready. All cmd_* fields are latched at that edge. cmd_valid while not ready is ignored; the requester holds it.
- States: IDLE, EXEC, LOADI, MUL_ADD, MUL_SHL, ILLEGAL. From IDLE, on accept, go to EXEC (code 0-7), LOADI (8), MUL_ADD (9) or ILLEGAL (10-15).
- Idle ALU drive: alu_op=2, alu_r1=0, alu_r2=0.
- EXEC: alu_op=code, alu_r1=reg[rs1], alu_r2=reg[rs2]. At the next edge: reg[rd] and result <= alu_out; done <= 1; go to IDLE. Accept at edge k, so write and done rise at edge k+1.
- LOADI: alu_op=2, alu_r1=imm, alu_r2=0. Next edge behaves as EXEC. Latency 1.
- MUL: on accept, A<=reg[rs1], B<=reg[rs2], ACC<=0, cnt<=0.
  - MUL_ADD: alu_op=0, r1=ACC, r2=A. At the edge, ACC<=alu_out only if B[0]=1; go to MUL_SHL.
  - MUL_SHL: alu_op=3, r1=A, r2=0. At the edge, A<=alu_out, B<=B>>1 (internal shift), cnt<=cnt+1.
  - If cnt==7 at that edge: reg[rd] and result <= ACC, done <= 1, go to IDLE. Otherwise go to MUL_ADD.
  - Fixed latency: write and done at edge k+16. Result = (rs1*rs2) mod 256.
  - rd may equal rs1/rs2: operands are snapshotted at accept.
- ILLEGAL: next edge sets done<=1 and err<=1; no write; result unchanged; go to IDLE.
- Arithmetic: 8-bit modulo. Sub wraps (5-20=241). No flags.
- done/err: registered, high exactly one cycle.
- Back-to-back: cmd_ready is high in the same cycle done is high. A new command accepted there reads the already-updated regfile; no forwarding needed. Peak throughput is 1 single-op command per 2 cycles.
- dbg_data reflects a write from the cycle after the write edge.

Test Plan:
- Reset; LOADI r0=5, LOADI r1=20, ADD(0) r2=r0+r1 -> each done exactly 1 cycle after accept; result 5, 20, 25; dbg r2=25.
- LOADI r0=96, r1=69; SUB r3=r0-r1 -> 27; SUB r3=r1-r0 -> 229; NOT r0 of 0xAA -> 0x55; SHL 255 -> 254; SHR 255 -> 127; AND 8,7 -> 0; OR 8,7 -> 15.
- MUL r2=13*11 -> done exactly 16 cycles after accept, result 143. MUL 255*255 -> 1. MUL x*0 -> 0. MUL r0=r0*r0 with r0=12 -> 144. cmd_ready low throughout.
- cmd_code=12 -> done and err high for one cycle at k+1; all registers and result unchanged.
- Reset asserted during MUL cycle 7 -> no done; regs all 0; cmd_ready=1 after release; next ADD works.
- cmd_valid held high through a MUL with ADD r0=r2+r2 queued -> accepted in the cycle done rises; uses the new r2 (143+143=30).

Source files
------------

// File: rtl/alu_sequencer.sv
// Command sequencer for an external 8-bit combinational ALU: owns a 4x8 register
// file, runs single-cycle ALU ops, LOADI, and MUL as an 8-step shift-add loop.
module alu_sequencer #(
    parameter int NUM_REGS  = 4,
    parameter int MUL_ITERS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_code,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_r1,
    output logic [7:0] alu_r2,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_out,
    output logic       done,
    output logic [7:0] result,
    output logic       err,
    output logic       busy,
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic [2:0] dbg_state
);

    // Handshake: a command transfers at the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and the requester holds cmd_* stable until then.

    localparam int          CNT_W     = $clog2(MUL_ITERS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);
    localparam logic [2:0]  OP_ADD    = 3'd0;
    localparam logic [2:0]  OP_PASS   = 3'd2;
    localparam logic [2:0]  OP_SHL    = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_LOADI   = 3'd2,
        S_MUL_ADD = 3'd3,
        S_MUL_SHL = 3'd4,
        S_ILLEGAL = 3'd5
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0]       regs [NUM_REGS];
    logic [2:0]       op_q;
    logic [1:0]       rd_q;
    logic [1:0]       rs1_q;
    logic [1:0]       rs2_q;
    logic [7:0]       imm_q;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic [7:0]       mul_acc;
    logic [CNT_W-1:0] mul_cnt;

    logic       accept;
    logic       mul_last;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       done_nx;
    logic       err_nx;

    assign accept    = cmd_valid && cmd_ready;
    assign mul_last  = (mul_cnt == LAST_ITER);
    assign busy      = (state != S_IDLE);
    assign dbg_data  = regs[dbg_addr];
    assign dbg_state = state;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_code < 4'd8) begin
                        state_nx = S_EXEC;
                    end else if (cmd_code == 4'd8) begin
                        state_nx = S_LOADI;
                    end else if (cmd_code == 4'd9) begin
                        state_nx = S_MUL_ADD;
                    end else begin
                        state_nx = S_ILLEGAL;
                    end
                end
            end
            S_EXEC, S_LOADI, S_ILLEGAL: state_nx = S_IDLE;
            S_MUL_ADD:                  state_nx = S_MUL_SHL;
            S_MUL_SHL:                  state_nx = mul_last ? S_IDLE : S_MUL_ADD;
            default:                    state_nx = S_IDLE;
        endcase
    end

    // Output logic: ALU drive, writeback select and retire pulses
    always_comb begin
        cmd_ready = (state == S_IDLE);
        alu_op    = OP_PASS;
        alu_r1    = '0;
        alu_r2    = '0;
        wr_en     = 1'b0;
        wr_data   = alu_out;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        case (state)
            S_EXEC: begin
                alu_op  = op_q;
                alu_r1  = regs[rs1_q];
                alu_r2  = regs[rs2_q];
                wr_en   = 1'b1;
                done_nx = 1'b1;
            end
            S_LOADI: begin
                alu_r1  = imm_q;
                wr_en   = 1'b1;
                done_nx = 1'b1;
            end
            S_MUL_ADD: begin
                alu_op = OP_ADD;
                alu_r1 = mul_acc;
                alu_r2 = mul_a;
            end
            S_MUL_SHL: begin
                alu_op = OP_SHL;
                alu_r1 = mul_a;
                if (mul_last) begin
                    wr_en   = 1'b1;
                    wr_data = mul_acc;
                    done_nx = 1'b1;
                end
            end
            S_ILLEGAL: begin
                done_nx = 1'b1;
                err_nx  = 1'b1;
            end
            default: ;
        endcase
    end

    // Command latch and MUL temporaries; operands are snapshotted so rd may alias rs1/rs2
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else begin
            if (accept) begin
                op_q  <= cmd_code[2:0];
                rd_q  <= cmd_rd;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
                imm_q <= cmd_imm;
                if (cmd_code == 4'd9) begin
                    mul_a   <= regs[cmd_rs1];
                    mul_b   <= regs[cmd_rs2];
                    mul_acc <= '0;
                    mul_cnt <= '0;
                end
            end
            if (state == S_MUL_ADD && mul_b[0]) begin
                mul_acc <= alu_out;
            end
            if (state == S_MUL_SHL) begin
                mul_a   <= alu_out;
                mul_b   <= {1'b0, mul_b[7:1]};
                mul_cnt <= mul_cnt + 1'b1;
            end
        end
    end

    // Register file, result and retire pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[rd_q] <= wr_data;
                result     <= wr_data;
            end
            done <= done_nx;
            err  <= err_nx;
        end
    end

endmodule
